// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
// Requests use a req/ack handshake, so memory latency can vary.
interface if_fetch_stage_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues imem reads at the PC and fills the IF/ID register.
// Define IF_FETCH_PERF_EN to add the perf_fetched / perf_wait saturating counters.
module if_fetch_stage #(
  parameter int                 ADDR_W   = 8,
  parameter int                 INSTR_W  = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_hold,
  input  logic               flush,
  input  logic               stall,
  if_fetch_stage_if.master   imem,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_pc_plus4
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_wait
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_REQ,
    S_HOLD
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               req_q;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               kill;
  logic [INSTR_W-1:0] skid;
  logic [INSTR_W-1:0] load_data;
  logic               load_ifid;
  logic               capture_skid;
  logic               set_kill;
  logic               clr_kill;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = fetch_addr;
  assign load_data      = (state == S_HOLD) ? skid : imem.imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Flush outranks a killed response, which outranks stall, which outranks delivery.
  always_comb begin
    next_state   = state;
    pc_hold      = 1'b1;
    load_ifid    = 1'b0;
    capture_skid = 1'b0;
    set_kill     = 1'b0;
    clr_kill     = 1'b0;
    case (state)
      S_IDLE:  next_state = S_ISSUE;
      S_ISSUE: next_state = S_REQ;
      S_REQ: begin
        if (imem.imem_ack) begin
          if (flush || kill) begin
            clr_kill   = 1'b1;
            next_state = S_ISSUE;
          end else if (stall) begin
            capture_skid = 1'b1;
            next_state   = S_HOLD;
          end else begin
            load_ifid  = 1'b1;
            next_state = S_ISSUE;
          end
        end else if (flush) begin
          set_kill = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          next_state = S_ISSUE;
        end else if (!stall) begin
          load_ifid  = 1'b1;
          next_state = S_ISSUE;
        end
      end
      default: next_state = S_IDLE;
    endcase
    if (flush || load_ifid) begin
      pc_hold = 1'b0;
    end
  end

  // The in-flight request is never aborted; a flush only marks its response for discard.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q         <= 1'b0;
      fetch_addr    <= '0;
      kill          <= 1'b0;
      skid          <= '0;
      ifid_valid    <= 1'b0;
      ifid_instr    <= NOP_WORD;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
    end else begin
      req_q <= (next_state == S_REQ);
      if (state == S_ISSUE) begin
        fetch_addr <= pc_in;
      end
      if (set_kill) begin
        kill <= 1'b1;
      end else if (clr_kill) begin
        kill <= 1'b0;
      end
      if (capture_skid) begin
        skid <= imem.imem_rdata;
      end
      if (flush) begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_WORD;
      end else if (load_ifid) begin
        ifid_valid    <= 1'b1;
        ifid_instr    <= load_data;
        ifid_pc       <= fetch_addr;
        ifid_pc_plus4 <= fetch_addr + ADDR_W'(4);
      end else if (!stall) begin
        ifid_valid <= 1'b0;
      end
    end
  end

`ifdef IF_FETCH_PERF_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_wait    <= '0;
    end else begin
      if (load_ifid && (perf_fetched != 16'hFFFF)) begin
        perf_fetched <= perf_fetched + 16'd1;
      end
      if ((((state == S_REQ) && !imem.imem_ack) || (state == S_HOLD)) &&
          (perf_wait != 16'hFFFF)) begin
        perf_wait <= perf_wait + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a per-cycle vector table for the main flow,
// then hand-written sequences for flush, flush+stall, address wrap and reset mid-request.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic [7:0]  pc_in;
  logic        pc_hold;
  logic        flush;
  logic        stall;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic [7:0]  ifid_pc_plus4;

  int check_count = 0;
  int error_count = 0;

  if_fetch_stage_if #(.ADDR_W(8), .INSTR_W(32)) imem_bus ();

  if_fetch_stage #(
    .ADDR_W   (8),
    .INSTR_W  (32),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .pc_hold       (pc_hold),
    .flush         (flush),
    .stall         (stall),
    .imem          (imem_bus),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per clock: inputs driven on the falling edge, outputs expected just after.
  typedef struct {
    logic        rst;
    logic [7:0]  pc;
    logic        flush;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic        e_hold;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [7:0]  e_pc;
    logic [7:0]  e_p4;
  } vec_t;

  vec_t vecs [17];

  task automatic applyStimulus(input logic r, input logic [7:0] pc, input logic fl,
                               input logic st, input logic ack, input logic [31:0] rd);
    @(negedge clk);
    rst                 = r;
    pc_in               = pc;
    flush               = fl;
    stall               = st;
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = rd;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic e_hold, input logic e_req,
                          input logic [7:0] e_addr, input logic e_valid,
                          input logic [31:0] e_instr, input logic [7:0] e_pc,
                          input logic [7:0] e_p4);
    checkOutput({tag, ".pc_hold"},       32'(pc_hold),            32'(e_hold));
    checkOutput({tag, ".imem_req"},      32'(imem_bus.imem_req),  32'(e_req));
    checkOutput({tag, ".imem_addr"},     32'(imem_bus.imem_addr), 32'(e_addr));
    checkOutput({tag, ".ifid_valid"},    32'(ifid_valid),         32'(e_valid));
    checkOutput({tag, ".ifid_instr"},    ifid_instr,              e_instr);
    checkOutput({tag, ".ifid_pc"},       32'(ifid_pc),            32'(e_pc));
    checkOutput({tag, ".ifid_pc_plus4"}, 32'(ifid_pc_plus4),      32'(e_p4));
  endtask

  initial begin
    rst                 = 1'b1;
    pc_in               = 8'h00;
    flush               = 1'b0;
    stall               = 1'b0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;

    //          rst  pc     fl    st    ack   rdata           hold  req   addr   valid instr           pc     p4
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h00, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h00, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 8'h00, 1'b0, 32'h0,         8'h00, 8'h00};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h8C01_0004, 1'b0, 1'b1, 8'h00, 1'b0, 32'h0,         8'h00, 8'h00};
    vecs[4]  = '{1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 8'h00, 1'b1, 32'h8C01_0004, 8'h00, 8'h04};
    vecs[5]  = '{1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h10, 1'b0, 32'h8C01_0004, 8'h00, 8'h04};
    vecs[6]  = '{1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h10, 1'b0, 32'h8C01_0004, 8'h00, 8'h04};
    vecs[7]  = '{1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h10, 1'b0, 32'h8C01_0004, 8'h00, 8'h04};
    vecs[8]  = '{1'b0, 8'h10, 1'b0, 1'b0, 1'b1, 32'h2010_0010, 1'b0, 1'b1, 8'h10, 1'b0, 32'h8C01_0004, 8'h00, 8'h04};
    vecs[9]  = '{1'b0, 8'h14, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 8'h10, 1'b1, 32'h2010_0010, 8'h10, 8'h14};
    vecs[10] = '{1'b0, 8'h14, 1'b0, 1'b1, 1'b1, 32'hAC02_0008, 1'b1, 1'b1, 8'h14, 1'b1, 32'h2010_0010, 8'h10, 8'h14};
    vecs[11] = '{1'b0, 8'h14, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 8'h14, 1'b1, 32'h2010_0010, 8'h10, 8'h14};
    vecs[12] = '{1'b0, 8'h14, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 8'h14, 1'b1, 32'h2010_0010, 8'h10, 8'h14};
    vecs[13] = '{1'b0, 8'h14, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 8'h14, 1'b1, 32'h2010_0010, 8'h10, 8'h14};
    vecs[14] = '{1'b0, 8'h14, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 8'h14, 1'b1, 32'h2010_0010, 8'h10, 8'h14};
    vecs[15] = '{1'b0, 8'h18, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 8'h14, 1'b1, 32'hAC02_0008, 8'h14, 8'h18};
    vecs[16] = '{1'b0, 8'h18, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'h18, 1'b0, 32'hAC02_0008, 8'h14, 8'h18};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].pc, vecs[i].flush, vecs[i].stall,
                    vecs[i].ack, vecs[i].rdata);
      checkAll($sformatf("row%0d", i), vecs[i].e_hold, vecs[i].e_req, vecs[i].e_addr,
               vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_p4);
    end

    $display("[TB] flush during outstanding request");
    applyStimulus(1'b0, 8'h18, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("flush_req.pc_hold", 32'(pc_hold), 32'd0);
    applyStimulus(1'b0, 8'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    checkAll("flush_req.after", 1'b1, 1'b1, 8'h18, 1'b0, 32'h0, 8'h14, 8'h18);
    applyStimulus(1'b0, 8'h40, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checkOutput("late_ack.pc_hold", 32'(pc_hold), 32'd1);
    applyStimulus(1'b0, 8'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    checkAll("late_ack.discard", 1'b1, 1'b0, 8'h18, 1'b0, 32'h0, 8'h14, 8'h18);
    applyStimulus(1'b0, 8'h40, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
    checkAll("redirect.req", 1'b0, 1'b1, 8'h40, 1'b0, 32'h0, 8'h14, 8'h18);

    $display("[TB] flush together with stall");
    applyStimulus(1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 32'h0);
    checkAll("flush_stall.before", 1'b0, 1'b0, 8'h40, 1'b1, 32'h1111_1111, 8'h40, 8'h44);
    applyStimulus(1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 32'h0);
    checkAll("flush_stall.after", 1'b1, 1'b1, 8'h44, 1'b0, 32'h0, 8'h40, 8'h44);

    $display("[TB] address wrap");
    applyStimulus(1'b0, 8'h44, 1'b0, 1'b0, 1'b1, 32'h2222_2222);
    applyStimulus(1'b0, 8'hFC, 1'b0, 1'b0, 1'b0, 32'h0);
    checkAll("wrap.prev", 1'b1, 1'b0, 8'h44, 1'b1, 32'h2222_2222, 8'h44, 8'h48);
    applyStimulus(1'b0, 8'hFC, 1'b0, 1'b0, 1'b1, 32'h3333_3333);
    checkAll("wrap.req", 1'b0, 1'b1, 8'hFC, 1'b0, 32'h2222_2222, 8'h44, 8'h48);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
    checkAll("wrap.load", 1'b1, 1'b0, 8'hFC, 1'b1, 32'h3333_3333, 8'hFC, 8'h00);

    $display("[TB] reset during outstanding request");
    applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_req.imem_req", 32'(imem_bus.imem_req), 32'd1);
    checkOutput("rst_req.imem_addr", 32'(imem_bus.imem_addr), 32'h00);
    applyStimulus(1'b0, 8'h20, 1'b0, 1'b0, 1'b1, 32'h4444_4444);
    checkAll("rst_req.reset", 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 32'h0);
    checkAll("rst_req.ack_ignored", 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 32'h0);
    checkAll("rst_req.reissue", 1'b1, 1'b1, 8'h20, 1'b0, 32'h0, 8'h00, 8'h00);

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly downstream of the PC register. It takes the current PC value and issues a read to instruction memory using a req/ack handshake, where memory latency can vary. The fetched word is placed into the IF/ID pipeline register together with its PC and PC+4. The block drives `pc_hold` back to the PC write-enable path so that the PC only advances when an instruction has been delivered or a redirect is taken. It also handles decode stalls and branch flushes.

Parameters:
- ADDR_W, 8, width of PC and instruction address.
- INSTR_W, 32, instruction word width.
- NOP_WORD, 32'h0000_0000, value loaded into `ifid_instr` on reset or flush.

Ports:
- clk  in  1  system clock; all state in this block updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- pc_in  in  ADDR_W  current PC value; it changes only on the falling edge of clk.
- pc_hold  out  1  combinational; 1 means the PC write path must keep its value.
- flush  in  1  branch/jump redirect; the PC loads its target on the following falling edge.
- stall  in  1  decode hazard; the IF/ID register must hold its contents.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  ADDR_W  read address; stable while `imem_req` is 1.
- imem_ack  in  1  read data valid this cycle; honoured only in S_REQ.
- imem_rdata  in  INSTR_W  read data.
- ifid_valid  out  1  the IF/ID register holds a live instruction.
- ifid_instr  out  INSTR_W  fetched instruction.
- ifid_pc  out  ADDR_W  address of `ifid_instr`.
- ifid_pc_plus4  out  ADDR_W  `ifid_pc` + 4, modulo 2^ADDR_W.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values, from any state: state=S_IDLE, imem_req=0, imem_addr=0, ifid_valid=0, ifid_instr=NOP_WORD, ifid_pc=0, ifid_pc_plus4=0, kill=0, skid register=0.
- States: S_IDLE, S_ISSUE, S_REQ, S_HOLD.
- S_IDLE:
  - Entered only after reset. Lasts one cycle, then goes to S_ISSUE.
  - pc_hold=1.
- S_ISSUE:
  - Latches fetch_addr <= pc_in, sets imem_req<=1, goes to S_REQ.
  - pc_hold=1.
- S_REQ:
  - imem_req=1 and imem_addr=fetch_addr, held until ack. pc_hold=1, except in the delivery cycle.
  - ack with kill=0, flush=0, stall=0: load IF/ID (valid=1, instr=rdata, pc=fetch_addr, pc_plus4=fetch_addr+4), drop imem_req, set pc_hold=0 this cycle, go to S_ISSUE.
  - ack with stall=1: capture rdata into the skid register, drop imem_req, go to S_HOLD.
  - ack with kill=1: discard the data, clear kill, go to S_ISSUE.
- S_HOLD:
  - imem_req=0, pc_hold=1 while stall=1.
  - When stall=0: load IF/ID from the skid register, set pc_hold=0 this cycle, go to S_ISSUE.
- Flush (highest priority; wins over stall and ack):
  - ifid_valid<=0, ifid_instr<=NOP_WORD, and pc_hold=0 so the PC takes the redirect.
  - In S_REQ without ack: set kill=1 and keep the request until ack. Memory requests are never aborted.
  - In S_REQ with ack, or in S_HOLD: discard the data and go to S_ISSUE.
  - In S_IDLE or S_ISSUE: the state sequence is unchanged.
- Bubbles:
  - If stall=0 and no instruction is loaded this cycle, ifid_valid<=0 (ifid_instr unchanged).
  - If stall=1, all IF/ID registers hold.
- Throughput: at most one instruction per 2 cycles with zero-latency ack. With memory latency N cycles, the pitch is N+2 cycles.
- Wrap: for fetch_addr = 2^ADDR_W-4, pc_plus4 = 0, with no flag.
- Reset mid-request: the pending ack is ignored because the block is in S_IDLE. The next request is issued at the current pc_in.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- Defined:
  - Adds outputs `perf_fetched` [15:0] and `perf_wait` [15:0], both 0 on reset.
  - `perf_fetched` increments on each IF/ID load of a live instruction.
  - `perf_wait` increments on each cycle spent in S_REQ without ack, or in S_HOLD.
  - Both counters saturate at 16'hFFFF.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then run, pc_in=8'h00, ack on the first S_REQ cycle, rdata=32'h8C01_0004 → ifid_valid=1, ifid_instr=32'h8C01_0004, ifid_pc=8'h00, ifid_pc_plus4=8'h04; pc_hold=0 for exactly that cycle.
- 3-cycle ack latency, pc_in=8'h10 → imem_req=1 and imem_addr=8'h10 held for 3 cycles; pc_hold=1 until delivery; ifid_pc=8'h10.
- stall=1 for 4 cycles when ack arrives with rdata=32'hAC02_0008 → IF/ID keeps its old contents and pc_hold=1; on stall=0 IF/ID gets 32'hAC02_0008.
- flush during S_REQ before ack, with the redirect target PC 8'h40 → ifid_valid=0; the late ack is discarded; the next imem_addr is 8'h40.
- flush and stall together while ifid_valid=1 → ifid_valid=0 and ifid_instr=NOP_WORD next cycle; pc_hold=0.
- pc_in=8'hFC fetch → ifid_pc_plus4=8'h00. Reset asserted mid-S_REQ → all outputs return to reset values on the next edge.
